moving_average_multichannel: RTL and testbench
==============================================

Name: moving_average_multichannel

Overview:
- Parametrised successor to the single-channel power-of-two moving average used on the price path.
- Serves up to CHANNELS time-interleaved streams (e.g. per-instrument prices), one sample per clock on any channel.
- Window is 2^k with k selected at run time up to 2^MAX_N.
- Adds valid handshake, window-full indication, optional rounding and in-place reconfiguration.

Parameters:
- DATA_WIDTH, 16, signed sample and average width.
- MAX_N, 3, maximum window log2; per-channel history depth is 2^MAX_N.
- CHANNELS, 4, number of independent channels.
- ROUND, 0, 0 = truncate (arithmetic shift, toward -inf); 1 = round half up, i.e. add 2^(k-1) before shifting when k>0.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_load  in  1  single-cycle pulse: apply cfg_win_log2 and flush all channels.
- cfg_win_log2  in  $clog2(MAX_N+1)  requested window log2 k.
- in_valid  in  1  sample qualifier.
- in_chan  in  max(1,$clog2(CHANNELS))  channel of sample.
- in_data  in  DATA_WIDTH  signed sample.
- out_valid  out  1  average qualifier.
- out_chan  out  same as in_chan  channel of average.
- out_data  out  DATA_WIDTH  signed average.
- out_full  out  1  window for out_chan held 2^k samples when this average was produced.
- win_log2  out  $clog2(MAX_N+1)  currently active k.

Behaviour:
- Reset (async assert, sync release):
  - out_valid, out_chan, out_data, out_full = 0.
  - win_log2 = MAX_N.
  - All per-channel accumulators, fill counts and write pointers = 0.
  - History storage needs no reset; unfilled entries are never read into the sum.
- Per-channel state:
  - acc[c] is signed, DATA_WIDTH+MAX_N bits wide; it cannot overflow.
  - cnt[c] saturates at W=2^k.
  - wptr[c] is a MAX_N-bit wrapping pointer into hist[c].
- Accepted sample (in_valid=1, cfg_load=0, in_chan<CHANNELS):
  - acc' = acc + in_data - (cnt==W ? hist[c][wptr-W mod 2^MAX_N] : 0).
  - hist[c][wptr] <= in_data.
  - wptr+1 wraps at 2^MAX_N.
  - cnt' = min(cnt+1, W).
- Samples with in_chan >= CHANNELS are ignored: no state change and no output.
- Average:
  - out_data = acc' >>> k, or (acc' + 2^(k-1)) >>> k when ROUND=1 and k>0.
  - Take the low DATA_WIDTH bits; the result always fits.
  - out_full = (cnt' == W).
  - Before the window fills, the average is computed over the partial sum, still divided by W.
- Latency: out_valid, out_chan, out_data and out_full are registered exactly 2 cycles after the accepted in_valid.
  - out_valid is a one-cycle pulse per accepted sample.
  - There is no backpressure.
- Throughput: 1 sample/cycle for any channel sequence, including the same channel on consecutive cycles.
  - In-flight acc/cnt/wptr updates must be forwarded; there are no stalls or bubbles.
- cfg_load:
  - Clamps cfg_win_log2 to MAX_N.
  - Updates win_log2 the next cycle.
  - Zeroes acc, cnt and wptr of every channel.
  - A sample presented in the same cycle is discarded.
  - Averages already in the pipeline still emerge, computed under the old k.
- k=0: out_data equals the sample; out_full=1 from the first sample.
- Reset mid-stream: pending outputs are lost, out_valid drops immediately, and every channel restarts from empty.

Test Plan:
- Partial fill and slide (CHANNELS=2, MAX_N=3, ROUND=0, cfg k=2):
  - Stimulus: ch0 samples 4, 8, 12, 16, 20 on consecutive cycles.
  - Required out_data: 1, 3, 6, 10, 14.
  - Required out_full: 0, 0, 0, 1, 1.
  - Each output arrives 2 cycles after its input.
- Channel isolation with back-to-back interleave:
  - Stimulus: ch0 = 4, 8, 12, 16 interleaved with ch1 = -8, -8, -8, -8.
  - Required ch1 out_data: -2, -4, -6, -8; ch0 results unchanged from the previous scenario; out_chan tags correct.
- Rounding (ROUND=1, k=2):
  - ch0 samples 1, 1, 1 -> out_data 0, 1, 1.
  - Fresh channel, sample -3 -> out_data -1.
- Reconfiguration:
  - Stimulus: cfg_load with k=0 mid-stream, with in_valid asserted in the same cycle.
  - Required: that sample produces no output; pipelined results still appear; win_log2=0.
  - Then samples 7, -5 -> out_data 7, -5 with out_full=1.
- Extremes and clamp:
  - cfg_win_log2=5 -> win_log2=3.
  - 8 samples of -32768 -> final out_data -32768, out_full=1.
  - Then 8 samples of 32767 -> final out_data 32767; no wrap.
  - in_chan=3 with CHANNELS=2 -> no out_valid.
- Async reset mid-stream:
  - Drop reset_n while two outputs are pending -> out_valid=0 immediately, and the pending outputs never appear.
  - After release, ch0 sample 8 (k=3) -> out_data 1, out_full=0.

Source files
------------

// File: rtl/moving_average_multichannel.sv
// Multichannel power-of-two moving average.
//
// Up to CHANNELS time-interleaved sample streams share one datapath. Each channel
// keeps a running sum of its last 2^k samples (k = win_log2, changeable at run
// time up to MAX_N). The average is the sum shifted right by k, so a partially
// filled window is still divided by the full 2^k.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   cfg_load           pulse: adopt cfg_win_log2 (clamped to MAX_N), flush all channels
//   cfg_win_log2       requested window log2
//   in_valid/chan/data sample input; channels >= CHANNELS are ignored
//   out_valid/chan     average qualifier and channel tag, 2 cycles after the sample
//   out_data           signed average
//   out_full           channel window held 2^k samples when this average was formed
//   win_log2           currently active window log2
module moving_average_multichannel #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_N      = 3,
    parameter int CHANNELS   = 4,
    parameter int ROUND      = 0,
    localparam int KW = (MAX_N > 0) ? $clog2(MAX_N + 1) : 1,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cfg_load,
    input  logic [KW-1:0]                cfg_win_log2,
    input  logic                         in_valid,
    input  logic [CW-1:0]                in_chan,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    output logic [CW-1:0]                out_chan,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_full,
    output logic [KW-1:0]                win_log2
);
    localparam int AW    = DATA_WIDTH + MAX_N;
    localparam int DEPTH = 1 << MAX_N;
    localparam int CNTW  = MAX_N + 1;

    // Per-channel state
    logic signed [AW-1:0]         acc_q  [CHANNELS];
    logic [CNTW-1:0]              cnt_q  [CHANNELS];
    logic [MAX_N-1:0]             wptr_q [CHANNELS];
    logic signed [DATA_WIDTH-1:0] hist_q [CHANNELS][DEPTH];
    logic [KW-1:0]                win_log2_q;

    // Stage 1: updated sum plus the k it must be divided by
    logic                         s1_valid_q;
    logic [CW-1:0]                s1_chan_q;
    logic signed [AW-1:0]         s1_acc_q;
    logic                         s1_full_q;
    logic [KW-1:0]                s1_k_q;

    logic                         in_range;
    logic                         accept;
    logic [CW-1:0]                ch_idx;
    logic [CNTW-1:0]              win;
    logic [CNTW-1:0]              cnt_cur;
    logic [CNTW-1:0]              cnt_nxt;
    logic [MAX_N-1:0]             wptr_cur;
    logic [MAX_N-1:0]             old_idx;
    logic                         full_before;
    logic signed [AW-1:0]         sample_ext;
    logic signed [AW-1:0]         drop;
    logic signed [AW-1:0]         acc_nxt;

    logic signed [AW:0]           rnd;
    logic signed [AW:0]           sum;
    logic signed [DATA_WIDTH-1:0] avg_d;

    // Channel state is committed in the accepting cycle, so a back-to-back sample
    // on the same channel already sees the updated acc/cnt/wptr.
    always_comb begin
        in_range    = int'(in_chan) < CHANNELS;
        accept      = in_valid && !cfg_load && in_range;
        ch_idx      = in_range ? in_chan : '0;
        win         = CNTW'(1) << win_log2_q;
        cnt_cur     = cnt_q[ch_idx];
        wptr_cur    = wptr_q[ch_idx];
        full_before = (cnt_cur == win);
        // Oldest sample of a full window; for W = 2^MAX_N this is the slot being overwritten.
        old_idx     = wptr_cur - win[MAX_N-1:0];
        sample_ext  = {{MAX_N{in_data[DATA_WIDTH-1]}}, in_data};
        drop        = '0;
        if (full_before) begin
            drop = {{MAX_N{hist_q[ch_idx][old_idx][DATA_WIDTH-1]}}, hist_q[ch_idx][old_idx]};
        end
        acc_nxt     = acc_q[ch_idx] + sample_ext - drop;
        cnt_nxt     = full_before ? cnt_cur : cnt_cur + CNTW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_log2_q <= KW'(MAX_N);
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c]  <= '0;
                cnt_q[c]  <= '0;
                wptr_q[c] <= '0;
            end
        end else if (cfg_load) begin
            win_log2_q <= (int'(cfg_win_log2) > MAX_N) ? KW'(MAX_N) : cfg_win_log2;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c]  <= '0;
                cnt_q[c]  <= '0;
                wptr_q[c] <= '0;
            end
        end else if (accept) begin
            acc_q[ch_idx]  <= acc_nxt;
            cnt_q[ch_idx]  <= cnt_nxt;
            wptr_q[ch_idx] <= wptr_cur + MAX_N'(1);
        end
    end

    // History is never read before it is written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            hist_q[ch_idx][wptr_cur] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_chan_q  <= '0;
            s1_acc_q   <= '0;
            s1_full_q  <= 1'b0;
            s1_k_q     <= '0;
        end else begin
            s1_valid_q <= accept;
            s1_chan_q  <= ch_idx;
            s1_acc_q   <= acc_nxt;
            s1_full_q  <= (cnt_nxt == win);
            // k travels with the sum so averages in flight across cfg_load keep the old k.
            s1_k_q     <= win_log2_q;
        end
    end

    // One guard bit keeps the rounding add from overflowing the signed sum.
    always_comb begin
        rnd = '0;
        if (ROUND != 0 && s1_k_q != '0) begin
            rnd = (AW + 1)'(1) << (s1_k_q - KW'(1));
        end
        sum   = {s1_acc_q[AW-1], s1_acc_q} + rnd;
        avg_d = DATA_WIDTH'(sum >>> s1_k_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_data  <= '0;
            out_full  <= 1'b0;
        end else begin
            out_valid <= s1_valid_q;
            out_chan  <= s1_chan_q;
            out_data  <= avg_d;
            out_full  <= s1_full_q;
        end
    end

    assign win_log2 = win_log2_q;

endmodule

// File: tb/tb_moving_average_multichannel.sv
// Bench for moving_average_multichannel.
// dut_t: 3 channels, truncating (2-bit in_chan, so channel 3 is out of range).
// dut_r: 2 channels, rounding; shares the stimulus with dut_t through in_chan[0].
// dut_c: MAX_N=4 so its 3-bit cfg field can exceed MAX_N; only win_log2 is observed.
module tb_moving_average_multichannel;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 cfg_load = 1'b0;
    logic [1:0]           cfg_win_log2 = '0;
    logic                 in_valid = 1'b0;
    logic [1:0]           in_chan = '0;
    logic signed [DW-1:0] in_data = '0;
    logic                 c_cfg_load = 1'b0;
    logic [2:0]           c_cfg = '0;

    logic                 t_ov, t_of, r_ov, r_of, c_ov, c_of;
    logic [1:0]           t_oc, t_wl, r_wl;
    logic [0:0]           r_oc, c_oc;
    logic [2:0]           c_wl;
    logic signed [DW-1:0] t_od, r_od, c_od;

    moving_average_multichannel #(.DATA_WIDTH(DW), .MAX_N(3), .CHANNELS(3), .ROUND(0)) dut_t (
        .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_win_log2(cfg_win_log2),
        .in_valid(in_valid), .in_chan(in_chan), .in_data(in_data),
        .out_valid(t_ov), .out_chan(t_oc), .out_data(t_od), .out_full(t_of), .win_log2(t_wl)
    );

    moving_average_multichannel #(.DATA_WIDTH(DW), .MAX_N(3), .CHANNELS(2), .ROUND(1)) dut_r (
        .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_win_log2(cfg_win_log2),
        .in_valid(in_valid), .in_chan(in_chan[0:0]), .in_data(in_data),
        .out_valid(r_ov), .out_chan(r_oc), .out_data(r_od), .out_full(r_of), .win_log2(r_wl)
    );

    moving_average_multichannel #(.DATA_WIDTH(DW), .MAX_N(4), .CHANNELS(2), .ROUND(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .cfg_load(c_cfg_load), .cfg_win_log2(c_cfg),
        .in_valid(1'b0), .in_chan(1'b0), .in_data('0),
        .out_valid(c_ov), .out_chan(c_oc), .out_data(c_od), .out_full(c_of), .win_log2(c_wl)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int chan;
        int data;
        bit full;
    } rec_t;

    int   cyc = 0;
    int   last_cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    rec_t cap_t[$], cap_r[$], exp_t[$], exp_r[$];
    int   mq[2][4][$];   // reference window contents per model and channel
    int   mk = 3;        // reference window log2

    function automatic rec_t mkrec(input int c, input int ch, input int d, input bit f);
        rec_t r;
        r.cyc = c; r.chan = ch; r.data = d; r.full = f;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (t_ov) cap_t.push_back(mkrec(cyc, int'(t_oc), int'(t_od), t_of));
        if (r_ov) cap_r.push_back(mkrec(cyc, int'(r_oc), int'(r_od), r_of));
    end

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) mq[d][c].delete();
    endtask

    // Average of the last min(n, 2^k) samples, always divided by 2^k, floored.
    task automatic model_push(input int dut, input int ch, input int d);
        int     w;
        longint s;
        int     q;
        w = 1 << mk;
        s = 0;
        mq[dut][ch].push_back(d);
        while (mq[dut][ch].size() > w) mq[dut][ch].delete(0);
        for (int i = 0; i < mq[dut][ch].size(); i++) s += mq[dut][ch][i];
        if (dut == 1 && mk > 0) s += w / 2;
        q = int'(s / w);
        if ((s % w) != 0 && s < 0) q -= 1;
        if (dut == 0) exp_t.push_back(mkrec(cyc + 2, ch, q, mq[dut][ch].size() == w));
        else          exp_r.push_back(mkrec(cyc + 2, ch, q, mq[dut][ch].size() == w));
    endtask

    task automatic send(input bit v, input int ch, input int d);
        @(negedge clk);
        cfg_load = 1'b0; in_valid = v; in_chan = ch[1:0]; in_data = d[DW-1:0];
        last_cyc = cyc;
        if (v) begin
            if (ch < 3) model_push(0, ch, d);
            model_push(1, ch % 2, d);
        end
    endtask

    task automatic do_cfg(input int k, input bit v, input int ch, input int d);
        @(negedge clk);
        cfg_load = 1'b1; cfg_win_log2 = k[1:0]; in_valid = v; in_chan = ch[1:0];
        in_data = d[DW-1:0];
        last_cyc = cyc;
        model_clear();
        mk = (k > 3) ? 3 : k;
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 0, 0);
    endtask

    task automatic clear_obs();
        cap_t.delete(); cap_r.delete(); exp_t.delete(); exp_r.delete();
    endtask

    task automatic test_reset();
        n_checks++;
        if (t_ov !== 1'b0 || t_oc !== 2'd0 || t_od !== 16'sd0 || t_of !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_t_outputs: got v=%b c=%0d d=%0d f=%b want all 0",
                     t_ov, t_oc, t_od, t_of);
        end
        n_checks++;
        if (r_ov !== 1'b0 || r_oc !== 1'b0 || r_od !== 16'sd0 || r_of !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_r_outputs: got v=%b c=%0d d=%0d f=%b want all 0",
                     r_ov, r_oc, r_od, r_of);
        end
        n_checks++;
        if (c_ov !== 1'b0 || c_oc !== 1'b0 || c_od !== 16'sd0 || c_of !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_c_outputs: got v=%b c=%0d d=%0d f=%b want all 0",
                     c_ov, c_oc, c_od, c_of);
        end
        n_checks++;
        if (t_wl !== 2'd3) begin n_fail++; $display("FAIL reset_t_win: got %0d want 3", t_wl); end
        n_checks++;
        if (r_wl !== 2'd3) begin n_fail++; $display("FAIL reset_r_win: got %0d want 3", r_wl); end
        n_checks++;
        if (c_wl !== 3'd4) begin n_fail++; $display("FAIL reset_c_win: got %0d want 4", c_wl); end
    endtask

    task automatic test_partial_fill();
        int ed[5] = '{1, 3, 6, 10, 14};
        bit ef[5] = '{0, 0, 0, 1, 1};
        int s0;
        do_cfg(2, 1'b0, 0, 0);
        idle(2);
        clear_obs();
        send(1'b1, 0, 4);
        s0 = last_cyc;
        for (int i = 1; i < 5; i++) send(1'b1, 0, 4 * (i + 1));
        idle(4);
        n_checks++;
        if (cap_t.size() != 5) begin
            n_fail++; $display("FAIL fill_count: got %0d want 5", cap_t.size());
        end
        for (int i = 0; i < 5 && i < cap_t.size(); i++) begin
            n_checks++;
            if (cap_t[i].data != ed[i] || cap_t[i].full != ef[i] || cap_t[i].chan != 0 ||
                cap_t[i].cyc != s0 + 2 + i) begin
                n_fail++;
                $display("FAIL fill_%0d: got d=%0d f=%0b c=%0d cyc=%0d want d=%0d f=%0b c=0 cyc=%0d",
                         i, cap_t[i].data, cap_t[i].full, cap_t[i].chan, cap_t[i].cyc,
                         ed[i], ef[i], s0 + 2 + i);
            end
        end
    endtask

    task automatic test_interleave();
        int ed[8] = '{1, -2, 3, -4, 6, -6, 10, -8};
        bit ef[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
        int s0;
        do_cfg(2, 1'b0, 0, 0);
        idle(2);
        clear_obs();
        s0 = cyc;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 0, 4 * (i + 1));
            if (i == 0) s0 = last_cyc;
            send(1'b1, 1, -8);
        end
        idle(4);
        n_checks++;
        if (cap_t.size() != 8) begin
            n_fail++; $display("FAIL ilv_count: got %0d want 8", cap_t.size());
        end
        for (int i = 0; i < 8 && i < cap_t.size(); i++) begin
            n_checks++;
            if (cap_t[i].data != ed[i] || cap_t[i].full != ef[i] || cap_t[i].chan != i % 2 ||
                cap_t[i].cyc != s0 + 2 + i) begin
                n_fail++;
                $display("FAIL ilv_%0d: got d=%0d f=%0b c=%0d cyc=%0d want d=%0d f=%0b c=%0d cyc=%0d",
                         i, cap_t[i].data, cap_t[i].full, cap_t[i].chan, cap_t[i].cyc,
                         ed[i], ef[i], i % 2, s0 + 2 + i);
            end
        end
    endtask

    task automatic test_rounding();
        int er[4] = '{0, 1, 1, -1};
        int et[4] = '{0, 0, 0, -1};
        int ec[4] = '{0, 0, 0, 1};
        do_cfg(2, 1'b0, 0, 0);
        idle(2);
        clear_obs();
        repeat (3) send(1'b1, 0, 1);
        send(1'b1, 1, -3);
        idle(4);
        n_checks++;
        if (cap_r.size() != 4 || cap_t.size() != 4) begin
            n_fail++;
            $display("FAIL rnd_count: got r=%0d t=%0d want 4 each", cap_r.size(), cap_t.size());
        end
        for (int i = 0; i < 4 && i < cap_r.size() && i < cap_t.size(); i++) begin
            n_checks++;
            if (cap_r[i].data != er[i] || cap_r[i].chan != ec[i]) begin
                n_fail++;
                $display("FAIL rnd_round_%0d: got d=%0d c=%0d want d=%0d c=%0d",
                         i, cap_r[i].data, cap_r[i].chan, er[i], ec[i]);
            end
            n_checks++;
            if (cap_t[i].data != et[i]) begin
                n_fail++;
                $display("FAIL rnd_trunc_%0d: got %0d want %0d", i, cap_t[i].data, et[i]);
            end
        end
    endtask

    task automatic test_reconfig();
        int ed[4] = '{1, 3, 7, -5};
        bit ef[4] = '{0, 0, 1, 1};
        int eo[4] = '{2, 3, 5, 6};
        int s0;
        do_cfg(2, 1'b0, 0, 0);
        idle(2);
        clear_obs();
        send(1'b1, 0, 4);
        s0 = last_cyc;
        send(1'b1, 0, 8);
        do_cfg(0, 1'b1, 0, 100);
        send(1'b1, 0, 7);
        send(1'b1, 0, -5);
        idle(4);
        n_checks++;
        if (t_wl !== 2'd0 || r_wl !== 2'd0) begin
            n_fail++; $display("FAIL cfg_win: got t=%0d r=%0d want 0", t_wl, r_wl);
        end
        n_checks++;
        if (cap_t.size() != 4) begin
            n_fail++; $display("FAIL cfg_count: got %0d want 4", cap_t.size());
        end
        for (int i = 0; i < 4 && i < cap_t.size(); i++) begin
            n_checks++;
            if (cap_t[i].data != ed[i] || cap_t[i].full != ef[i] || cap_t[i].cyc != s0 + eo[i]) begin
                n_fail++;
                $display("FAIL cfg_%0d: got d=%0d f=%0b cyc=%0d want d=%0d f=%0b cyc=%0d",
                         i, cap_t[i].data, cap_t[i].full, cap_t[i].cyc, ed[i], ef[i], s0 + eo[i]);
            end
        end
    endtask

    task automatic test_extremes();
        int ck[3] = '{5, 7, 2};
        int cw[3] = '{4, 4, 2};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            c_cfg_load = 1'b1; c_cfg = ck[i][2:0];
            @(negedge clk);
            c_cfg_load = 1'b0;
            n_checks++;
            if (int'(c_wl) != cw[i]) begin
                n_fail++; $display("FAIL clamp_%0d: got %0d want %0d", ck[i], c_wl, cw[i]);
            end
        end
        do_cfg(3, 1'b0, 0, 0);
        idle(2);
        n_checks++;
        if (t_wl !== 2'd3) begin n_fail++; $display("FAIL ext_win: got %0d want 3", t_wl); end
        clear_obs();
        repeat (8) send(1'b1, 0, -32768);
        repeat (8) send(1'b1, 0, 32767);
        idle(4);
        n_checks++;
        if (cap_t.size() != 16 || cap_r.size() != 16) begin
            n_fail++;
            $display("FAIL ext_count: got t=%0d r=%0d want 16", cap_t.size(), cap_r.size());
        end else begin
            n_checks++;
            if (cap_t[6].data != -28672 || cap_t[6].full != 1'b0) begin
                n_fail++;
                $display("FAIL ext_neg7: got d=%0d f=%0b want -28672 0", cap_t[6].data, cap_t[6].full);
            end
            n_checks++;
            if (cap_t[7].data != -32768 || cap_t[7].full != 1'b1 || cap_r[7].data != -32768) begin
                n_fail++;
                $display("FAIL ext_neg8: got t=%0d f=%0b r=%0d want -32768 1 -32768",
                         cap_t[7].data, cap_t[7].full, cap_r[7].data);
            end
            n_checks++;
            if (cap_t[15].data != 32767 || cap_t[15].full != 1'b1 || cap_r[15].data != 32767) begin
                n_fail++;
                $display("FAIL ext_pos8: got t=%0d f=%0b r=%0d want 32767 1 32767",
                         cap_t[15].data, cap_t[15].full, cap_r[15].data);
            end
        end
        clear_obs();
        send(1'b1, 3, 123);
        idle(4);
        n_checks++;
        if (cap_t.size() != 0) begin
            n_fail++; $display("FAIL bad_chan: got %0d outputs want 0", cap_t.size());
        end
    endtask

    task automatic test_async_reset();
        do_cfg(1, 1'b0, 0, 0);
        idle(2);
        clear_obs();
        send(1'b1, 0, 50);
        send(1'b1, 0, 60);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (t_ov !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", t_ov); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (t_ov !== 1'b0 || r_ov !== 1'b0) begin
            n_fail++; $display("FAIL rst_drop: got t=%b r=%b want 0", t_ov, r_ov);
        end
        model_clear();
        mk = 3;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n_checks++;
        if (t_wl !== 2'd3 || c_wl !== 3'd4) begin
            n_fail++; $display("FAIL rst_win: got t=%0d c=%0d want 3 4", t_wl, c_wl);
        end
        send(1'b1, 0, 8);
        idle(4);
        n_checks++;
        if (cap_t.size() != 1 || cap_r.size() != 1) begin
            n_fail++;
            $display("FAIL rst_count: got t=%0d r=%0d want 1", cap_t.size(), cap_r.size());
        end else begin
            n_checks++;
            if (cap_t[0].data != 1 || cap_t[0].full != 1'b0 || cap_t[0].chan != 0 ||
                cap_r[0].data != 1) begin
                n_fail++;
                $display("FAIL rst_after: got t=%0d f=%0b c=%0d r=%0d want 1 0 0 1",
                         cap_t[0].data, cap_t[0].full, cap_t[0].chan, cap_r[0].data);
            end
        end
    endtask

    task automatic test_random();
        int d;
        do_cfg(int'($urandom_range(0, 3)), 1'b0, 0, 0);
        idle(2);
        clear_obs();
        repeat (400) begin
            d = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 39) == 0)
                do_cfg(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), d);
            else
                send(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), d);
        end
        idle(4);
        n_checks++;
        if (cap_t.size() != exp_t.size() || cap_r.size() != exp_r.size()) begin
            n_fail++;
            $display("FAIL rand_count: got t=%0d r=%0d want t=%0d r=%0d",
                     cap_t.size(), cap_r.size(), exp_t.size(), exp_r.size());
        end
        for (int i = 0; i < cap_t.size() && i < exp_t.size(); i++) begin
            n_checks++;
            if (cap_t[i] != exp_t[i]) begin
                n_fail++;
                $display("FAIL rand_t_%0d: got cyc=%0d c=%0d d=%0d f=%0b want cyc=%0d c=%0d d=%0d f=%0b",
                         i, cap_t[i].cyc, cap_t[i].chan, cap_t[i].data, cap_t[i].full,
                         exp_t[i].cyc, exp_t[i].chan, exp_t[i].data, exp_t[i].full);
            end
        end
        for (int i = 0; i < cap_r.size() && i < exp_r.size(); i++) begin
            n_checks++;
            if (cap_r[i] != exp_r[i]) begin
                n_fail++;
                $display("FAIL rand_r_%0d: got cyc=%0d c=%0d d=%0d f=%0b want cyc=%0d c=%0d d=%0d f=%0b",
                         i, cap_r[i].cyc, cap_r[i].chan, cap_r[i].data, cap_r[i].full,
                         exp_r[i].cyc, exp_r[i].chan, exp_r[i].data, exp_r[i].full);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_partial_fill();
        test_interleave();
        test_rounding();
        test_reconfig();
        test_extremes();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
